key_encoder: RTL and testbench

//  Encodes 8 raw push-button lines into a 3-bit key code, the inverse of the 3->8 LED decoder.

---
 rtl/key_encoder_if.sv | 34 +++
 rtl/key_encoder.sv | 172 +++++++++++++++++
 tb/tb_key_encoder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/key_encoder_if.sv
// -----------------------------------------------------------------------------
// key_encoder_if
//   Bundles the key encoder's control inputs and key-code outputs.
//   Signals:
//     en_i       encoder enable (driven by master)
//     keys_i[7:0] raw push-button lines, 1 = pressed (driven by master)
//     code_o[2:0] lowest-numbered pressed key, held after release
//     valid_o    at least one debounced key pressed while enabled
//     press_o    1-cycle strobe: new code accepted
//     release_o  1-cycle strobe: all keys released
//     multi_o    more than one debounced key pressed
//   Modports:
//     master : drives en_i/keys_i, observes the outputs (board / testbench)
//     slave  : the encoder itself
// -----------------------------------------------------------------------------
interface key_encoder_if;
  logic       en_i;
  logic [7:0] keys_i;
  logic [2:0] code_o;
  logic       valid_o;
  logic       press_o;
  logic       release_o;
  logic       multi_o;

  modport master (
    output en_i, keys_i,
    input  code_o, valid_o, press_o, release_o, multi_o
  );

  modport slave (
    input  en_i, keys_i,
    output code_o, valid_o, press_o, release_o, multi_o
  );
endinterface

// File: rtl/key_encoder.sv
// -----------------------------------------------------------------------------
// key_encoder
//   Turns 8 raw push-button lines into a 3-bit key code (inverse of the 3->8
//   LED decoder). Buttons are synchronised (2 flops), debounced (a new vector
//   must be seen DEBOUNCE_CYCLES times in a row), then priority-encoded with
//   the lowest index winning. A 2-state FSM produces a held code, a level
//   valid, a multi-key flag and single-cycle press/release strobes, all
//   registered.
//   Ports:
//     clk_i  single system clock, rising edge
//     rst_i  synchronous reset, active-high
//     bus    key_encoder_if.slave (en_i, keys_i in; code/valid/strobes out)
//   Parameters:
//     DEBOUNCE_CYCLES  consecutive equal samples to accept a vector (>= 2)
// -----------------------------------------------------------------------------
module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  key_encoder_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // Synchroniser and debouncer state
  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [7:0]       r_cand;
  logic [7:0]       r_stable;
  logic [CNT_W-1:0] r_cnt;

  // FSM state and registered outputs
  state_t     r_state;
  logic [2:0] r_code;
  logic       r_valid;
  logic       r_press;
  logic       r_release;
  logic       r_multi;

  // Combinational next values
  state_t     w_state_n;
  logic [2:0] w_code_n;
  logic       w_valid_n;
  logic       w_press_n;
  logic       w_release_n;
  logic       w_multi_n;

  logic [2:0] w_enc;
  logic [3:0] w_ones;
  logic       w_any;
  logic       w_multi;

  // ---------------------------------------------------------------------------
  // Synchroniser + debouncer. Runs regardless of en_i so that a key held
  // across a disable is already stable when the encoder is re-enabled.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the 2-flop synchroniser.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= bus.keys_i;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_cand;
        r_cnt    <= CNT_SAT;
      end else if (r_cnt < CNT_LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // r_cnt == CNT_SAT: saturated, nothing changes until the input moves
    end
  end

  // ---------------------------------------------------------------------------
  // Priority encoder (lowest set bit wins) and popcount for the multi flag.
  // Scanning downward lets the lowest index overwrite any higher one.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    w_enc  = 3'd0;
    w_ones = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_stable[i]) w_enc = 3'(i);
      w_ones = w_ones + {3'b000, r_stable[i]};
    end
  end

  assign w_any   = |r_stable;
  assign w_multi = (w_ones > 4'd1);

  // ---------------------------------------------------------------------------
  // FSM: next state and next registered outputs.
  // Disable overrides everything: drop to IDLE silently with code held.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_n   = r_state;
    w_code_n    = r_code;
    w_press_n   = 1'b0;
    w_release_n = 1'b0;

    if (!bus.en_i) begin
      w_state_n = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            w_state_n = ST_HELD;
            w_code_n  = w_enc;
            w_press_n = 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_any) begin
            w_state_n   = ST_IDLE;
            w_release_n = 1'b1;
          end else if (w_enc != r_code) begin
            w_code_n  = w_enc;
            w_press_n = 1'b1;
          end
          // Same lowest key with higher keys added/removed: no strobe,
          // only the multi flag tracks the change.
        end
        default: w_state_n = ST_IDLE;
      endcase
    end

    w_valid_n = (w_state_n == ST_HELD);
    w_multi_n = (w_state_n == ST_HELD) && w_multi;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_code    <= 3'd0;
      r_valid   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_code    <= w_code_n;
      r_valid   <= w_valid_n;
      r_press   <= w_press_n;
      r_release <= w_release_n;
      r_multi   <= w_multi_n;
    end
  end

  assign bus.code_o    = r_code;
  assign bus.valid_o   = r_valid;
  assign bus.press_o   = r_press;
  assign bus.release_o = r_release;
  assign bus.multi_o   = r_multi;

endmodule

// File: tb/tb_key_encoder.sv
// -----------------------------------------------------------------------------
// tb_key_encoder
//   Directed bench for key_encoder with DEBOUNCE_CYCLES=4. Inputs change on
//   the falling edge; outputs are sampled on the falling edge that follows
//   the rising edge of interest. With keys steady from before edge 1, the
//   press strobe is visible after edge 8.
// -----------------------------------------------------------------------------
module tb_key_encoder;

  logic clk_i = 1'b0;
  logic rst_i;

  int checks   = 0;
  int failures = 0;
  int n_press;
  int n_release;

  key_encoder_if u_if ();

  key_encoder #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (u_if.slave)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, return on the following falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  // Tick n times while counting strobes.
  task automatic tick_count(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (u_if.press_o)   n_press++;
      if (u_if.release_o) n_release++;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] keys);
    u_if.keys_i = keys;
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    u_if.en_i   = 1'b1;
    u_if.keys_i = 8'h00;
    @(negedge clk_i);

    // ---- Reset with all keys pressed ----
    do_reset(8'hFF);
    // (reset released here; values seen reflect the reset edges)
    check("rst_code",    {5'd0, u_if.code_o}, 8'd0);
    check("rst_valid",   {7'd0, u_if.valid_o}, 8'd0);
    check("rst_press",   {7'd0, u_if.press_o}, 8'd0);
    check("rst_release", {7'd0, u_if.release_o}, 8'd0);
    check("rst_multi",   {7'd0, u_if.multi_o}, 8'd0);
    n_press = 0; n_release = 0;
    tick_count(7);
    check("rst_no_early_press", 8'(n_press), 8'd0);
    tick();
    check("rst_press_e8", {7'd0, u_if.press_o}, 8'd1);
    check("rst_code_e8",  {5'd0, u_if.code_o},  8'd0);
    check("rst_multi_e8", {7'd0, u_if.multi_o}, 8'd1);
    tick();
    check("rst_press_1cyc", {7'd0, u_if.press_o}, 8'd0);

    // ---- Single key 5, then release ----
    do_reset(8'h20);
    n_press = 0; n_release = 0;
    tick_count(7);
    check("k5_no_early_press", 8'(n_press), 8'd0);
    tick();
    check("k5_press", {7'd0, u_if.press_o}, 8'd1);
    check("k5_code",  {5'd0, u_if.code_o},  8'd5);
    check("k5_valid", {7'd0, u_if.valid_o}, 8'd1);
    check("k5_multi", {7'd0, u_if.multi_o}, 8'd0);
    tick();
    check("k5_press_1cyc", {7'd0, u_if.press_o}, 8'd0);
    check("k5_valid_hold", {7'd0, u_if.valid_o}, 8'd1);
    u_if.keys_i = 8'h00;
    n_press = 0; n_release = 0;
    tick_count(7);
    check("k5_no_early_release", 8'(n_release), 8'd0);
    tick();
    check("k5_release",      {7'd0, u_if.release_o}, 8'd1);
    check("k5_rel_valid",    {7'd0, u_if.valid_o},   8'd0);
    check("k5_rel_code",     {5'd0, u_if.code_o},    8'd5);
    check("k5_rel_no_press", {7'd0, u_if.press_o},   8'd0);
    tick();
    check("k5_release_1cyc", {7'd0, u_if.release_o}, 8'd0);

    // ---- Bounce on key 2 ----
    do_reset(8'h00);
    n_press = 0; n_release = 0;
    for (int i = 0; i < 5; i++) begin
      u_if.keys_i = 8'h04; tick_count(2);
      u_if.keys_i = 8'h00; tick_count(2);
    end
    check("bnc_no_press_during", 8'(n_press), 8'd0);
    check("bnc_valid_during",    {7'd0, u_if.valid_o}, 8'd0);
    u_if.keys_i = 8'h04;
    tick_count(12);
    check("bnc_one_press",  8'(n_press),   8'd1);
    check("bnc_no_release", 8'(n_release), 8'd0);
    check("bnc_code",       {5'd0, u_if.code_o},  8'd2);
    check("bnc_valid",      {7'd0, u_if.valid_o}, 8'd1);

    // ---- Priority / multi ----
    do_reset(8'h10);
    tick(8);
    check("pm_press4", {7'd0, u_if.press_o}, 8'd1);
    check("pm_code4",  {5'd0, u_if.code_o},  8'd4);
    tick(2);
    u_if.keys_i = 8'h12;
    n_press = 0; n_release = 0;
    tick_count(7);
    check("pm_no_early_press", 8'(n_press), 8'd0);
    check("pm_code_still4",    {5'd0, u_if.code_o}, 8'd4);
    tick();
    check("pm_press1", {7'd0, u_if.press_o}, 8'd1);
    check("pm_code1",  {5'd0, u_if.code_o},  8'd1);
    check("pm_multi1", {7'd0, u_if.multi_o}, 8'd1);
    tick(2);
    u_if.keys_i = 8'h02;
    n_press = 0; n_release = 0;
    tick_count(10);
    check("pm_drop_no_press",   8'(n_press),   8'd0);
    check("pm_drop_no_release", 8'(n_release), 8'd0);
    check("pm_drop_multi",      {7'd0, u_if.multi_o}, 8'd0);
    check("pm_drop_code",       {5'd0, u_if.code_o},  8'd1);
    check("pm_drop_valid",      {7'd0, u_if.valid_o}, 8'd1);

    // ---- Enable ----
    do_reset(8'h80);
    tick(8);
    check("en_press7", {7'd0, u_if.press_o}, 8'd1);
    tick(2);
    u_if.en_i = 1'b0;
    n_press = 0; n_release = 0;
    tick_count(1);
    check("en_off_valid", {7'd0, u_if.valid_o}, 8'd0);
    check("en_off_code",  {5'd0, u_if.code_o},  8'd7);
    tick_count(3);
    check("en_off_no_release", 8'(n_release), 8'd0);
    check("en_off_no_press",   8'(n_press),   8'd0);
    u_if.en_i = 1'b1;
    tick();
    check("en_on_press", {7'd0, u_if.press_o}, 8'd1);
    check("en_on_code",  {5'd0, u_if.code_o},  8'd7);
    check("en_on_valid", {7'd0, u_if.valid_o}, 8'd1);
    tick();
    check("en_on_press_1cyc", {7'd0, u_if.press_o}, 8'd0);

    // ---- Reset mid-debounce ----
    do_reset(8'h00);
    u_if.keys_i = 8'h08;
    n_press = 0; n_release = 0;
    tick_count(4);
    rst_i = 1'b1;
    tick_count(1);
    rst_i = 1'b0;
    check("mid_rst_no_press", 8'(n_press), 8'd0);
    tick_count(7);
    check("mid_no_early_press", 8'(n_press), 8'd0);
    check("mid_no_release",     8'(n_release), 8'd0);
    tick();
    check("mid_press_e8", {7'd0, u_if.press_o}, 8'd1);
    check("mid_code3",    {5'd0, u_if.code_o},  8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
